// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared FSM state type and multiplier-count constants for the complex MAC
package fixed_point_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL1,
        MUL2,
        MUL3,
        DONE
    } cmac_state_t;

    localparam int NUM_MULTS_SERIAL   = 1;
    localparam int NUM_MULTS_PARALLEL = 3;

    function automatic bit num_mults_legal(input int m);
        return (m == NUM_MULTS_SERIAL) || (m == NUM_MULTS_PARALLEL);
    endfunction

endpackage

// File: rtl/fixed_point_cmac_narrow.sv
// fixed_point_cmac_narrow: n+g to n narrowing, clamps when FIXED_POINT_CMAC_SATURATE_EN is defined, else wraps
module fixed_point_cmac_narrow #(
    parameter int n = 32,
    parameter int g = 8
) (
    input  logic signed [n+g-1:0] din,
    output logic signed [n-1:0]   dout
);

`ifdef FIXED_POINT_CMAC_SATURATE_EN
    logic [g:0] hi;
    logic       fits;

    // value fits when every bit above the n-bit sign bit matches it; otherwise clamp by sign
    always_comb begin
        hi   = din[n+g-1:n-1];
        fits = (&hi) | ~(|hi);
        dout = fits ? din[n-1:0] :
               din[n+g-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
    end
`else
    assign dout = din[n-1:0];
`endif

endmodule

// File: rtl/fixed_point_seq_complex_mac.sv
// fixed_point_seq_complex_mac: streaming complex dot product with optional conj(b), 1 or 3 multipliers
// Output narrowing saturates when FIXED_POINT_CMAC_SATURATE_EN is defined, wraps otherwise.
module fixed_point_seq_complex_mac
    import fixed_point_pkg::*;
#(
    parameter int n         = 32,
    parameter int d         = 16,
    parameter int num_mults = 1,
    parameter int g         = 8,
    parameter int cnt_w     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             recv_val,
    output logic             recv_rdy,
    input  logic [n-1:0]     ar,
    input  logic [n-1:0]     ac,
    input  logic [n-1:0]     br,
    input  logic [n-1:0]     bc,
    input  logic             conj,
    input  logic             last,
    output logic             send_val,
    input  logic             send_rdy,
    output logic [n-1:0]     cr,
    output logic [n-1:0]     cc,
    output logic [cnt_w-1:0] cnt
);

    localparam int a_w = n + g;
    localparam int m_w = n + 1;
    localparam int p_w = 2 * m_w;
    localparam bit par = (num_mults == NUM_MULTS_PARALLEL);

    // n+1 bit fixed-point multiplier: full-precision product, arithmetic shift, kept to accumulator width
    function automatic logic signed [a_w-1:0] fx_mul(input logic signed [m_w-1:0] x,
                                                     input logic signed [m_w-1:0] y);
        return a_w'((p_w'(x) * p_w'(y)) >>> d);
    endfunction

    function automatic logic signed [m_w-1:0] sx(input logic [n-1:0] v);
        return {v[n-1], v};
    endfunction

    cmac_state_t             state_q, state_d;
    logic signed [a_w-1:0]   acc_r_q, acc_r_d, acc_c_q, acc_c_d;
    logic signed [a_w-1:0]   t1, t2, t3;
    logic [cnt_w-1:0]        cnt_q, cnt_d;
    logic                    take, acc_last;

    assign take = (state_q == IDLE) && recv_val;

    if (par) begin : g_par
        logic signed [m_w-1:0] bcp;
        // three products straight from the live operands so each element accumulates on acceptance
        always_comb begin
            bcp = conj ? -sx(bc) : sx(bc);
            t1  = fx_mul(sx(ar), sx(br));
            t2  = fx_mul(sx(ac), bcp);
            t3  = fx_mul(sx(ar) + sx(ac), sx(br) + bcp);
        end
        assign acc_last = last;
    end else begin : g_ser
        logic [n-1:0]          ar_q, ar_d, ac_q, ac_d, br_q, br_d, bc_q, bc_d;
        logic                  conj_q, conj_d, last_q, last_d;
        logic signed [a_w-1:0] p1_q, p1_d, p2_q, p2_d, pm;
        logic signed [m_w-1:0] bcp, mx, my;
        // latch the element on acceptance, then steer P1, P2, P3 through the one multiplier
        always_comb begin
            ar_d   = take ? ar : ar_q;
            ac_d   = take ? ac : ac_q;
            br_d   = take ? br : br_q;
            bc_d   = take ? bc : bc_q;
            conj_d = take ? conj : conj_q;
            last_d = take ? last : last_q;
            bcp    = conj_q ? -sx(bc_q) : sx(bc_q);
            mx     = state_q == MUL1 ? sx(ar_q) : state_q == MUL2 ? sx(ac_q) : sx(ar_q) + sx(ac_q);
            my     = state_q == MUL1 ? sx(br_q) : state_q == MUL2 ? bcp : sx(br_q) + bcp;
            pm     = fx_mul(mx, my);
            p1_d   = state_q == MUL1 ? pm : p1_q;
            p2_d   = state_q == MUL2 ? pm : p2_q;
        end
        // operand and partial-product registers
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ar_q   <= '0;
                ac_q   <= '0;
                br_q   <= '0;
                bc_q   <= '0;
                conj_q <= 1'b0;
                last_q <= 1'b0;
                p1_q   <= '0;
                p2_q   <= '0;
            end else begin
                ar_q   <= ar_d;
                ac_q   <= ac_d;
                br_q   <= br_d;
                bc_q   <= bc_d;
                conj_q <= conj_d;
                last_q <= last_d;
                p1_q   <= p1_d;
                p2_q   <= p2_d;
            end
        end
        assign t1       = p1_q;
        assign t2       = p2_q;
        assign t3       = pm;
        assign acc_last = last_q;
    end

    // sequencing, accumulation and saturating element count
    always_comb begin
        state_d = state_q;
        acc_r_d = acc_r_q;
        acc_c_d = acc_c_q;
        cnt_d   = (take && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        if ((take && par) || state_q == MUL3) begin
            acc_r_d = acc_r_q + t1 - t2;
            acc_c_d = acc_c_q + t3 - t1 - t2;
        end
        unique case (state_q)
            IDLE:    state_d = !recv_val ? IDLE : !par ? MUL1 : last ? DONE : IDLE;
            MUL1:    state_d = MUL2;
            MUL2:    state_d = MUL3;
            MUL3:    state_d = acc_last ? DONE : IDLE;
            DONE: begin
                if (send_rdy) begin
                    state_d = IDLE;
                    acc_r_d = '0;
                    acc_c_d = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, accumulators and count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_r_q <= '0;
            acc_c_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_r_q <= acc_r_d;
            acc_c_q <= acc_c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign recv_rdy = (state_q == IDLE);
    assign send_val = (state_q == DONE);
    assign cnt      = cnt_q;

    fixed_point_cmac_narrow #(.n(n), .g(g)) u_narrow_r (.din(acc_r_q), .dout(cr));
    fixed_point_cmac_narrow #(.n(n), .g(g)) u_narrow_c (.din(acc_c_q), .dout(cc));

endmodule

// File: tb/tb_fixed_point_seq_complex_mac.sv
// tb_fixed_point_seq_complex_mac: directed checks for 3- and 1-multiplier builds plus a 16-bit narrowing build
module tb_fixed_point_seq_complex_mac;

    localparam logic [31:0] ONE = 32'h0001_0000;
`ifdef FIXED_POINT_CMAC_SATURATE_EN
    localparam logic [31:0] NAR_EXP = 32'h0000_7FFF;
`else
    localparam logic [31:0] NAR_EXP = 32'h0000_1000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rv[3], rr[3], sv[3], sr[3], cj[3], lst[3];
    logic [31:0] ar_i[3], ac_i[3], br_i[3], bc_i[3];
    logic [31:0] cr_o[2], cc_o[2];
    logic [15:0] cr2, cc2;
    logic [15:0] cnt_o[3];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fixed_point_seq_complex_mac #(.num_mults(3)) u_m3 (
        .clk(clk), .reset(reset), .recv_val(rv[0]), .recv_rdy(rr[0]),
        .ar(ar_i[0]), .ac(ac_i[0]), .br(br_i[0]), .bc(bc_i[0]), .conj(cj[0]), .last(lst[0]),
        .send_val(sv[0]), .send_rdy(sr[0]), .cr(cr_o[0]), .cc(cc_o[0]), .cnt(cnt_o[0]));

    fixed_point_seq_complex_mac #(.num_mults(1)) u_m1 (
        .clk(clk), .reset(reset), .recv_val(rv[1]), .recv_rdy(rr[1]),
        .ar(ar_i[1]), .ac(ac_i[1]), .br(br_i[1]), .bc(bc_i[1]), .conj(cj[1]), .last(lst[1]),
        .send_val(sv[1]), .send_rdy(sr[1]), .cr(cr_o[1]), .cc(cc_o[1]), .cnt(cnt_o[1]));

    fixed_point_seq_complex_mac #(.n(16), .d(8), .g(8), .num_mults(1)) u_nar (
        .clk(clk), .reset(reset), .recv_val(rv[2]), .recv_rdy(rr[2]),
        .ar(ar_i[2][15:0]), .ac(ac_i[2][15:0]), .br(br_i[2][15:0]), .bc(bc_i[2][15:0]),
        .conj(cj[2]), .last(lst[2]),
        .send_val(sv[2]), .send_rdy(sr[2]), .cr(cr2), .cc(cc2), .cnt(cnt_o[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_cr(input int k);
        if (k == 2) return {16'h0, cr2};
        return cr_o[k];
    endfunction

    function automatic logic [31:0] get_cc(input int k);
        if (k == 2) return {16'h0, cc2};
        return cc_o[k];
    endfunction

    task automatic push(input int k, input logic [31:0] a_r, a_c, b_r, b_c, input logic c, l);
        int w = 0;
        while (!rr[k] && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("recv_rdy_wait", 32'(rr[k]), 32'd1);
        ar_i[k] = a_r;
        ac_i[k] = a_c;
        br_i[k] = b_r;
        bc_i[k] = b_c;
        cj[k]   = c;
        lst[k]  = l;
        rv[k]   = 1'b1;
        @(posedge clk);
        #1;
        rv[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int exp_lat);
        int lat = 1;
        while (!sv[k] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic expect_out(input int k, input string tag, input logic [31:0] er, ec, en);
        check({tag, ".cr"}, get_cr(k), er);
        check({tag, ".cc"}, get_cc(k), ec);
        check({tag, ".cnt"}, {16'h0, cnt_o[k]}, en);
    endtask

    task automatic pop(input int k);
        sr[k] = 1'b1;
        @(posedge clk);
        #1;
        sr[k] = 1'b0;
        check("idle_after_pop", 32'(rr[k]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rv[k] = 1'b0; sr[k] = 1'b0; cj[k] = 1'b0; lst[k] = 1'b0;
            ar_i[k] = '0; ac_i[k] = '0; br_i[k] = '0; bc_i[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst.recv_rdy", 32'(rr[k]), 32'd1);
            check("rst.send_val", 32'(sv[k]), 32'd0);
            expect_out(k, "rst", 32'h0, 32'h0, 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 2; k++) begin
            push(k, ONE, 2 * ONE, 3 * ONE, 4 * ONE, 1'b0, 1'b1);
            wait_done(k, k == 0 ? 1 : 4);
            expect_out(k, "single", 32'hFFFB_0000, 32'h000A_0000, 32'd1);
            pop(k);

            push(k, ONE, 2 * ONE, 3 * ONE, 4 * ONE, 1'b1, 1'b1);
            wait_done(k, k == 0 ? 1 : 4);
            expect_out(k, "conj", 32'h000B_0000, 32'h0002_0000, 32'd1);
            pop(k);

            push(k, ONE, 2 * ONE, 3 * ONE, 4 * ONE, 1'b0, 1'b0);
            push(k, ONE, 32'h0, ONE, ONE, 1'b0, 1'b1);
            wait_done(k, k == 0 ? 1 : 4);
            expect_out(k, "two", 32'hFFFC_0000, 32'h000B_0000, 32'd2);
            pop(k);

            push(k, ONE, 32'h0, ONE, ONE, 1'b0, 1'b1);
            wait_done(k, k == 0 ? 1 : 4);
            expect_out(k, "third", ONE, ONE, 32'd1);
            pop(k);

            push(k, ONE, 2 * ONE, 3 * ONE, 4 * ONE, 1'b0, 1'b1);
            wait_done(k, k == 0 ? 1 : 4);
            ar_i[k] = 7 * ONE; ac_i[k] = 5 * ONE; br_i[k] = 2 * ONE; bc_i[k] = ONE;
            lst[k] = 1'b1; rv[k] = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                check("bp.send_val", 32'(sv[k]), 32'd1);
                check("bp.recv_rdy", 32'(rr[k]), 32'd0);
                check("bp.cr", get_cr(k), 32'hFFFB_0000);
            end
            rv[k] = 1'b0;
            expect_out(k, "bp_hold", 32'hFFFB_0000, 32'h000A_0000, 32'd1);
            pop(k);
            push(k, ONE, 32'h0, ONE, ONE, 1'b0, 1'b1);
            wait_done(k, k == 0 ? 1 : 4);
            expect_out(k, "after_bp", ONE, ONE, 32'd1);
            pop(k);
        end

        push(2, 32'h6400, 32'h0, 32'h6400, 32'h0, 1'b0, 1'b1);
        wait_done(2, 4);
        expect_out(2, "narrow", NAR_EXP, 32'h0, 32'd1);
        pop(2);

        push(1, ONE, 2 * ONE, 3 * ONE, 4 * ONE, 1'b0, 1'b0);
        push(1, ONE, 32'h0, ONE, ONE, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("pre_reset.cr", get_cr(1), 32'hFFFB_0000);
        reset = 1'b0;
        #1;
        check("mid_rst.recv_rdy", 32'(rr[1]), 32'd1);
        check("mid_rst.send_val", 32'(sv[1]), 32'd0);
        expect_out(1, "mid_rst", 32'h0, 32'h0, 32'd0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        push(1, ONE, 32'h0, ONE, ONE, 1'b0, 1'b1);
        wait_done(1, 4);
        expect_out(1, "post_rst", ONE, ONE, 32'd1);
        pop(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fixed_point_seq_complex_mac.md
# fixed_point_seq_complex_mac

Sequential fixed-point complex multiply-accumulate. Consumes a stream of complex operand pairs terminated by a `last` flag and returns the sum of their complex products (optionally with `b` conjugated) as one result. The multiplier count trades area for throughput. Sits in the DSP datapath behind the FFT as the correlation/dot-product stage.

## Interface
- `n`, 32, operand and result bit width
- `d`, 16, fractional bits
- `num_mults`, 1, multipliers instantiated; legal values 1 or 3
- `g`, 8, accumulator guard bits; accumulator width is n+g
- `cnt_w`, 16, element-counter width
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-low reset
- `recv_val` in 1, `recv_rdy` out 1: input handshake
- `ar`, `ac`, `br`, `bc` in n each: real/imag parts of a and b, signed Q(n-d).d
- `conj` in 1: when 1, the element uses conj(b); sampled per element
- `last` in 1: marks the final element of the vector
- `send_val` out 1, `send_rdy` in 1: output handshake
- `cr`, `cc` out n each: accumulated result, real/imag
- `cnt` out cnt_w: elements accumulated into the current result; saturates at 2^cnt_w-1

## Operation
- Per element, bc' = conj ? -bc : bc. Products are p = (x*y) >>> d, computed at full 2n precision with arithmetic shift.
- Real part is P1 - P2; imag part is P3 - P1 - P2.
  - P1 = ar*br
  - P2 = ac*bc'
  - P3 = (ar+ac)(br+bc')
- Sums feeding P3 are formed at n+1 bits, so they never wrap.
- Each partial term is sign-extended to n+g bits and added into the accumulators `acc_r` and `acc_c`. Accumulators wrap at n+g bits.
- States and transitions:
  - IDLE: `recv_rdy`=1. On handshake, latch operands, `conj` and `last`; increment `cnt`. Go to MUL1 when num_mults=1. When num_mults=3, accumulate in the same cycle, then stay in IDLE, or go to DONE if `last`.
  - MUL1 → MUL2 → MUL3 (num_mults=1 only): one product per state through the single multiplier. Accumulate at the end of MUL3, then go to DONE if `last`, else IDLE.
  - DONE: `send_val`=1, `recv_rdy`=0. On `send_rdy`, clear accumulators and `cnt` and go to IDLE.
- `cr`/`cc` are the accumulators narrowed to n bits (see Configuration). They are combinational from the accumulators and are valid only while `send_val` is high.
- `recv_rdy` is 0 in MUL1–MUL3 and DONE. Input held during those states is ignored.

## Timing
- Reset (asynchronous, active-low) values:
  - state=IDLE
  - accumulators, latched operands and `cnt` = 0
  - `recv_rdy`=1, `send_val`=0, `cr`=`cc`=0
- Reset asserted mid-vector or in DONE discards all partial and pending results immediately.
- num_mults=3:
  - Throughput is 1 element per cycle.
  - `last` accepted at edge t → `send_val` high from t+1.
- num_mults=1:
  - Throughput is 1 element per 4 cycles (IDLE + 3 MUL).
  - `last` accepted at edge t → `send_val` high from t+4.
- `send_val` holds, and `cr`/`cc`/`cnt` stay stable, until `send_rdy`. With `send_rdy` tied high, DONE lasts exactly one cycle.
- A vector of one element (`last` on the first element) is legal. The next vector may begin in the cycle after the DONE handshake.
- `cnt` stops at all-ones; accumulation continues.

## Configuration
- Macro: `FIXED_POINT_CMAC_SATURATE_EN`.
- Defined: narrowing clamps each accumulator to the signed n-bit range, giving 2^(n-1)-1 or -2^(n-1).
- Undefined: narrowing keeps the low n bits of the accumulator (wrap). No clamp logic is synthesised.

## Structure
- Shared package `fixed_point_pkg` holds:
  - the state enum `cmac_state_t` {IDLE, MUL1, MUL2, MUL3, DONE}
  - the num_mults legality constants
- One sub-module: `fixed_point_cmac_narrow`, an n+g → n narrowing unit (saturate or wrap under the macro), instantiated once each for real and imag.
- Products use the existing combinational fixed-point multiplier. Its width is n+1 so that it can also carry the P3 operands.

## Test plan
All cases use n=32, d=16 unless stated; 1.0 = 0x00010000.
- Single element, both num_mults: a=1+2j, b=3+4j, conj=0, last=1 → cr=0xFFFB0000, cc=0x000A0000, cnt=1. `send_val` rises at t+1 (num_mults=3) or t+4 (num_mults=1).
- Conjugate: same operands with conj=1 → cr=0x000B0000, cc=0x00020000.
- Two-element vector: (1+2j)(3+4j) then (1+0j)(1+1j) with last → cr=0xFFFC0000, cc=0x000B0000, cnt=2. A third vector sent afterwards starts from zero.
- Backpressure: hold `send_rdy`=0 for 5 cycles in DONE → outputs stable, `recv_rdy`=0, and input offered meanwhile is not accepted.
- Narrowing, n=16, d=8, g=8: a=100+0j, b=100+0j.
  - Macro defined → cr=0x7FFF, cc=0.
  - Macro undefined → cr=0x1000, cc=0.
- Reset mid-vector: drop `reset` during MUL2 → `recv_rdy`=1, `send_val`=0, cr/cc=0 asynchronously. The next single-element vector returns only its own product.
